// File: rtl/wb_arbiter_if.sv
// wb_arbiter_if: bundle of the writeback arbiter's issue, ALU, load, hazard-query
// and register-file write signals.
//   slave  modport: the arbiter side (consumes issue/ALU/load/query inputs and
//                   drives alu_ready, busy flags, the write port and err).
//   master modport: the pipeline side that drives those inputs.
interface wb_arbiter_if #(
  parameter int XLEN = 32
);
  logic            iss_valid;
  logic [4:0]      iss_rd;
  logic            alu_valid;
  logic            alu_ready;
  logic [4:0]      alu_rd;
  logic [XLEN-1:0] alu_data;
  logic            ld_valid;
  logic [4:0]      ld_rd;
  logic [XLEN-1:0] ld_data;
  logic [4:0]      q_rs1;
  logic [4:0]      q_rs2;
  logic [4:0]      q_rd;
  logic            busy_rs1;
  logic            busy_rs2;
  logic            busy_rd;
  logic            RegWrite;
  logic [4:0]      WriteAddr;
  logic [XLEN-1:0] WriteData;
  logic            err;

  modport slave (
    input  iss_valid, iss_rd,
    input  alu_valid, alu_rd, alu_data,
    input  ld_valid, ld_rd, ld_data,
    input  q_rs1, q_rs2, q_rd,
    output alu_ready,
    output busy_rs1, busy_rs2, busy_rd,
    output RegWrite, WriteAddr, WriteData,
    output err
  );

  modport master (
    output iss_valid, iss_rd,
    output alu_valid, alu_rd, alu_data,
    output ld_valid, ld_rd, ld_data,
    output q_rs1, q_rs2, q_rd,
    input  alu_ready,
    input  busy_rs1, busy_rs2, busy_rd,
    input  RegWrite, WriteAddr, WriteData,
    input  err
  );
endinterface

// File: rtl/wb_arbiter.sv
// wb_arbiter: single writer of the register-file write port. Loads (which cannot
// be stalled) win the port; ALU results are queued in a small FIFO and drained
// whenever no load is present. A pending bit per architectural register (x1..x31)
// is set on issue and cleared when the matching write retires, so the issue
// stage can stall on RAW/WAW hazards through the busy_* query outputs.
//
// Ports:
//   clk  - clock, rising edge
//   rst  - asynchronous active-high reset
//   bus  - wb_arbiter_if.slave: issue, ALU result (valid/ready), load response,
//          hazard queries, register-file write port and sticky err flag
//
// Optional feature: define WB_ALU_BYPASS_EN to let an ALU result go straight to
// the write port (zero latency) when the FIFO is empty and no load is present.
module wb_arbiter #(
  parameter int FIFO_DEPTH = 4,
  parameter int XLEN       = 32
) (
  input  logic         clk,
  input  logic         rst,
  wb_arbiter_if.slave  bus
);
  localparam int AW = $clog2(FIFO_DEPTH);

  // FIFO storage and pointers (extra MSB distinguishes full from empty)
  logic [4:0]      fifo_rd_mem   [FIFO_DEPTH];
  logic [XLEN-1:0] fifo_data_mem [FIFO_DEPTH];
  logic [AW:0]     wr_ptr_reg;
  logic [AW:0]     rd_ptr_reg;

  logic [31:1]     pending_reg;
  logic [31:1]     pending_next;
  logic [31:1]     set_vec;
  logic [31:1]     clr_vec;
  logic [31:0]     pend_full;
  logic            err_reg;

  logic            empty;
  logic            full;
  logic            push;
  logic            pop;
  logic            bypass;
  logic            port_valid;
  logic [4:0]      port_rd;
  logic [XLEN-1:0] port_data;
  logic            retire;
  logic            err_event;

  assign empty = (wr_ptr_reg == rd_ptr_reg);
  assign full  = ((wr_ptr_reg ^ rd_ptr_reg) == {1'b1, {AW{1'b0}}});

  // Fixed-priority port selection: load, then FIFO head, then (optionally) a
  // bypassed ALU result.
  always_comb begin
    port_valid = 1'b0;
    port_rd    = 5'd0;
    port_data  = '0;
    pop        = 1'b0;
    bypass     = 1'b0;
    if (bus.ld_valid) begin
      port_valid = 1'b1;
      port_rd    = bus.ld_rd;
      port_data  = bus.ld_data;
    end else if (!empty) begin
      port_valid = 1'b1;
      port_rd    = fifo_rd_mem[rd_ptr_reg[AW-1:0]];
      port_data  = fifo_data_mem[rd_ptr_reg[AW-1:0]];
      pop        = 1'b1;
    end
`ifdef WB_ALU_BYPASS_EN
    else if (bus.alu_valid) begin
      // FIFO is empty here, so alu_ready is high and the result is accepted
      port_valid = 1'b1;
      port_rd    = bus.alu_rd;
      port_data  = bus.alu_data;
      bypass     = 1'b1;
    end
`endif
  end

  // rd=0 results are consumed but never reach the register file; the rst term
  // keeps the combinational load path quiet while reset is held.
  assign retire = port_valid && (port_rd != 5'd0) && !rst;

  assign push = bus.alu_valid && !full && !bypass;

  assign bus.alu_ready = !full;
  assign bus.RegWrite  = retire;
  assign bus.WriteAddr = retire ? port_rd : 5'd0;
  assign bus.WriteData = retire ? port_data : '0;

  // FIFO pointers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
    end else begin
      if (push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
    end
  end

  // FIFO storage needs no reset: the pointers define which entries are valid
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_rd_mem[wr_ptr_reg[AW-1:0]]   <= bus.alu_rd;
      fifo_data_mem[wr_ptr_reg[AW-1:0]] <= bus.alu_data;
    end
  end

  // Per-register set/clear decode; set wins over a same-edge clear
  genvar gi;
  generate
    for (gi = 1; gi < 32; gi++) begin : g_pend
      assign set_vec[gi] = bus.iss_valid && (bus.iss_rd == 5'(gi));
      assign clr_vec[gi] = retire && (port_rd == 5'(gi));
    end
  endgenerate

  assign pending_next = (pending_reg & ~clr_vec) | set_vec;

  // Bit 0 pinned low so x0 always reads not-busy and never counts as pending
  assign pend_full = {pending_reg, 1'b0};

  assign err_event = (retire && !pend_full[port_rd])
                   || (bus.iss_valid && (bus.iss_rd != 5'd0) && pend_full[bus.iss_rd])
                   || (bus.alu_valid && full);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pending_reg <= '0;
      err_reg     <= 1'b0;
    end else begin
      pending_reg <= pending_next;
      err_reg     <= err_reg | err_event;
    end
  end

  assign bus.err      = err_reg;
  assign bus.busy_rs1 = pend_full[bus.q_rs1];
  assign bus.busy_rs2 = pend_full[bus.q_rs2];
  assign bus.busy_rd  = pend_full[bus.q_rd];
endmodule

// File: doc/wb_arbiter.md
# wb_arbiter

Writeback arbiter and register scoreboard for the pipelined core: the single writer of the register file's write port (RegWrite/WriteAddr/WriteData). It merges ALU results and data-memory load responses, buffers ALU results in a small FIFO when a load wins the port, and tracks which architectural registers have writes in flight. The issue stage queries it to stall on RAW/WAW hazards.

## Interface
- FIFO_DEPTH, 4: ALU result FIFO entries; power of two, ≥2.
- XLEN, 32: data width.
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- iss_valid  in  1  issue stage dispatches an instruction that writes iss_rd.
- iss_rd  in  5  destination of the issued instruction.
- alu_valid  in  1  ALU result presented.
- alu_ready  out  1  FIFO can accept (`!full`).
- alu_rd  in  5  ALU destination.
- alu_data  in  XLEN  ALU result.
- ld_valid  in  1  load response; cannot be back-pressured.
- ld_rd  in  5  load destination.
- ld_data  in  XLEN  load data.
- q_rs1, q_rs2, q_rd  in  5 each  hazard query addresses.
- busy_rs1, busy_rs2, busy_rd  out  1 each  pending bit of queried register (0 for x0).
- RegWrite  out  1  register-file write enable.
- WriteAddr  out  5  register-file write address.
- WriteData  out  XLEN  register-file write data.
- err  out  1  sticky protocol-error flag.

## Operation
- State: `pending[31:1]` bit vector, ALU FIFO (rd + data per entry, rd/wr pointers with extra wrap bit), `err`.
- Issue: `iss_valid` with `iss_rd != 0` sets `pending[iss_rd]` at the clock edge. Issue with `iss_rd == 0` is ignored.
- Port arbitration each cycle, fixed priority:
  1. `ld_valid`: write port = load (RegWrite=1, WriteAddr=ld_rd, WriteData=ld_data).
  2. Else FIFO non-empty: write port = FIFO head, head popped.
  3. Else: RegWrite=0, WriteAddr=0, WriteData=0.
- ALU accept: `alu_valid && alu_ready` pushes {alu_rd, alu_data}. Push and pop in the same cycle allowed at any occupancy; full FIFO with simultaneous pop still reports alu_ready=0 (ready depends on registered count only).
- Retire: any write-port transaction with WriteAddr≠0 clears `pending[WriteAddr]` at that edge. rd=0 results are accepted/popped and drive RegWrite=0, no pending change.
- Same-edge set and clear of the same bit: set wins (err also set, see below).
- err set (sticky until reset) on: retire of an rd whose pending bit is 0; `iss_valid` to an rd already pending; `alu_valid` while full.
- Busy outputs are combinational reads of the registered `pending` vector; a register retiring this cycle still reads busy until the next edge.
- Users guarantee no issue to a busy rd (WAW), so FIFO/load reordering never reorders writes to one register.

## Timing
- Reset (async, immediate): pending=0, FIFO empty, err=0, alu_ready=1, RegWrite=0, WriteAddr=0, WriteData=0, all busy=0.
- Load: zero-latency, combinational from ld_* to write port.
- ALU: pushed at edge N, written to register file no earlier than cycle N+1 (without bypass), delayed one cycle per load occupying the port.
- Pending clears at the edge of the retiring write; busy low from the following cycle.
- Reset asserted mid-operation discards FIFO contents and pending bits; no write emitted while rst is high.

## Configuration
- `WB_ALU_BYPASS_EN` defined: when FIFO is empty and ld_valid=0, an accepted ALU result drives the write port combinationally in the same cycle and is not pushed (zero latency).
- Not defined: every ALU result passes through the FIFO; minimum one-cycle latency. All other behaviour identical.

## Test plan
- Reset: assert rst mid-cycle with 3 FIFO entries and pending[5]=1 -> outputs immediately zero, alu_ready=1, busy_rd for x5 =0.
- Single ALU: issue rd=7, next cycle alu rd=7 data=0xDEADBEEF -> write port x7=0xDEADBEEF on next cycle (same cycle with bypass), busy for x7 low the cycle after.
- Collision: ld rd=3 data=0x11 and alu rd=4 data=0x22 same cycle -> x3 written that cycle, x4 written next cycle.
- Full FIFO: hold ld_valid=1 for 6 cycles while issuing ALU results rd=1..6 -> alu_ready drops after 4 accepted; after ld_valid drops, x1..x4 written in order, then x5, x6 once re-accepted.
- x0 handling: issue rd=0, alu rd=0 data=0xFFFF -> RegWrite=0, busy=0, err=0.
- Protocol error: alu retire rd=9 with pending[9]=0 -> err=1 and stays 1 until rst.
